// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display: active-high segment glyphs,
// digit slot indices and the converter state type.
package stopwatch_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a set bit means the segment is lit.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Digit slot indices; slot 0 is the rightmost digit.
    localparam logic [1:0] DIGIT_SEC_ONES = 2'd0;
    localparam logic [1:0] DIGIT_SEC_TENS = 2'd1;
    localparam logic [1:0] DIGIT_MIN_ONES = 2'd2;
    localparam logic [1:0] DIGIT_MIN_TENS = 2'd3;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    // Glyph lookup that stays dark for non-decimal nibbles.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        pat = SEG_OFF;
        for (int i = 0; i < 10; i++) begin
            if (nibble == 4'(i)) begin
                pat = SEG_DIGIT[i];
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq7.sv
// Sequential 7-bit binary to two-digit BCD converter (double dabble,
// one shift per clock). Hundreds are discarded; legal inputs are 0-99.
module bin2bcd_seq7
    import stopwatch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state_reg, state_next;
    // Working register laid out as {tens, ones, remaining binary bits}.
    logic [14:0] work_reg, work_next;
    logic [2:0]  count_reg, count_next;
    logic [14:0] adjusted;

    // State, working register and shift counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= CONV_IDLE;
            work_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic: load on start, add-3 then shift seven times, flag done.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        adjusted   = work_reg;
        if (work_reg[14:11] >= 4'd5) begin
            adjusted[14:11] = work_reg[14:11] + 4'd3;
        end
        if (work_reg[10:7] >= 4'd5) begin
            adjusted[10:7] = work_reg[10:7] + 4'd3;
        end
        case (state_reg)
            CONV_IDLE: begin
                // A start that arrives while busy never reaches this branch.
                if (start) begin
                    work_next  = {8'd0, bin};
                    count_next = 3'd0;
                    state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                work_next  = {adjusted[13:0], 1'b0};
                count_next = count_reg + 3'd1;
                if (count_reg == 3'd6) begin
                    state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                state_next = CONV_IDLE;
            end
            default: begin
                state_next = CONV_IDLE;
            end
        endcase
    end

    assign busy = (state_reg != CONV_IDLE);
    assign done = (state_reg == CONV_DONE);
    assign tens = work_reg[14:11];
    assign ones = work_reg[10:7];

endmodule

// File: rtl/stopwatch_display_mux.sv
// Four-digit multiplexed 7-segment driver showing MM.SS. Minutes and
// seconds are snapshotted once per scan frame and converted to BCD in the
// background, so a frame never mixes digits of two different readings.
module stopwatch_display_mux
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] minutes,
    input  logic [6:0] seconds,
    input  logic       dp_on,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [3:0]       AN_IDLE  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       digit_idx_reg;
    logic             snap_pending_reg;
    logic             err_snap_reg;
    logic             err_reg;
    logic [3:0]       bcd_reg [0:3];
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [3:0]       an_reg;

    logic             tick;
    logic             snap_now;
    logic             conv_start;
    logic [6:0]       conv_bin  [0:1];
    logic [1:0]       conv_busy;
    logic [1:0]       conv_done;
    logic [3:0]       conv_tens [0:1];
    logic [3:0]       conv_ones [0:1];
    logic [3:0]       digit_sel;
    logic [3:0]       digit_val;
    logic             digit_lit;
    logic             dp_lit;
    logic [6:0]       seg_pat;
    logic [3:0]       an_pat;

    assign tick       = (div_cnt_reg == DIV_LAST);
    assign snap_now   = snap_pending_reg || (tick && (digit_idx_reg == DIGIT_MIN_TENS));
    assign conv_start = snap_now && (conv_busy == 2'b00);

    // Converter 0 handles seconds, converter 1 handles minutes.
    assign conv_bin[0] = seconds;
    assign conv_bin[1] = minutes;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            bin2bcd_seq7 u_conv (
                .clock (clock),
                .reset (reset),
                .start (conv_start),
                .bin   (conv_bin[gi]),
                .busy  (conv_busy[gi]),
                .done  (conv_done[gi]),
                .tens  (conv_tens[gi]),
                .ones  (conv_ones[gi])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign digit_sel[gi] = (digit_idx_reg == 2'(gi));
        end
    endgenerate

    // Refresh divider, digit scan index and the post-reset snapshot request.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_reg      <= '0;
            digit_idx_reg    <= DIGIT_SEC_ONES;
            snap_pending_reg <= 1'b1;
        end else begin
            div_cnt_reg      <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            snap_pending_reg <= 1'b0;
            if (tick) begin
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end
        end
    end

    // Range flag captured with the snapshot; BCD digits and the flag go live
    // together when the conversion finishes.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_snap_reg <= 1'b0;
            err_reg      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                bcd_reg[i] <= 4'd0;
            end
        end else begin
            if (conv_start) begin
                err_snap_reg <= (minutes > 7'd99) || (seconds > 7'd59);
            end
            if (conv_done[0]) begin
                err_reg <= err_snap_reg;
            end
            for (int i = 0; i < 2; i++) begin
                if (conv_done[i]) begin
                    bcd_reg[2*i]   <= conv_ones[i];
                    bcd_reg[2*i+1] <= conv_tens[i];
                end
            end
        end
    end

    // Active-high glyph, decimal point and anode for the current slot.
    always_comb begin
        digit_val = bcd_reg[digit_idx_reg];
        digit_lit = 1'b1;
        dp_lit    = 1'b0;
        seg_pat   = seg_pattern(digit_val);
        if (err_reg) begin
            seg_pat = SEG_DASH;
        end else begin
            if (BLANK_LEADING && (digit_idx_reg == DIGIT_MIN_TENS)
                    && (bcd_reg[DIGIT_MIN_TENS] == 4'd0)) begin
                digit_lit = 1'b0;
            end
            dp_lit = (digit_idx_reg == DIGIT_MIN_ONES) && dp_on;
        end
        if (!digit_lit) begin
            seg_pat = SEG_OFF;
            dp_lit  = 1'b0;
        end
        an_pat = digit_lit ? digit_sel : 4'b0000;
    end

    // Output registers: blank on reset and for the tick cycle, otherwise the
    // current slot with pin polarity applied.
    always_ff @(posedge clock) begin
        if (reset || tick) begin
            seg_reg <= SEG_IDLE;
            dp_reg  <= DP_IDLE;
            an_reg  <= AN_IDLE;
        end else begin
            seg_reg <= SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
            dp_reg  <= SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
            an_reg  <= AN_ACTIVE_LOW ? ~an_pat : an_pat;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule
